// File: rtl/led_pattern_sequencer.sv
// LED bank animator: prescaled step tick, 4-mode pattern FSM (COUNT/SWEEP/BLINK/OFF), pause and mode button.
// Optional macro LED_PWM_EN adds a 3-bit brightness input that PWM-gates the LED outputs.
module led_pattern_sequencer #(
  parameter int SLOW  = 21,
  parameter int NLEDS = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             next_mode,
  input  logic             pause,
`ifdef LED_PWM_EN
  input  logic [2:0]       brightness,
`endif
  output logic             tick,
  output logic [1:0]       mode,
  output logic [NLEDS-1:0] LEDS
);

  localparam int PW = (NLEDS > 2) ? $clog2(NLEDS) : 1;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    SWEEP = 2'd1,
    BLINK = 2'd2,
    OFF   = 2'd3
  } mode_t;

  mode_t            state, stateNext;
  logic [SLOW-1:0]  div;
  logic [NLEDS-1:0] count, countNext;
  logic [PW-1:0]    pos, posNext;
  logic             dirDown, dirDownNext;
  logic             blink, blinkNext;
  logic             prevNext;
  logic             step, modeEdge;
  logic [NLEDS-1:0] pattern, ledsNext;

  assign step     = (div == {SLOW{1'b1}}) && !pause;
  assign modeEdge = next_mode && !prevNext;
  assign tick     = step;
  assign mode     = state;

  // A mode change restarts the new pattern from its origin and swallows a coincident step.
  always_comb begin
    stateNext   = state;
    countNext   = count;
    posNext     = pos;
    dirDownNext = dirDown;
    blinkNext   = blink;
    if (modeEdge) begin
      stateNext   = mode_t'(state + 2'd1);
      countNext   = '0;
      posNext     = '0;
      dirDownNext = 1'b0;
      blinkNext   = 1'b0;
    end else if (step) begin
      case (state)
        COUNT: countNext = count + NLEDS'(1);
        SWEEP: begin
          if (!dirDown) begin
            posNext = pos + PW'(1);
            if (posNext == PW'(NLEDS - 1)) dirDownNext = 1'b1;
          end else begin
            posNext = pos - PW'(1);
            if (posNext == '0) dirDownNext = 1'b0;
          end
        end
        BLINK:   blinkNext = !blink;
        default: ;
      endcase
    end

    case (stateNext)
      COUNT:   pattern = countNext;
      SWEEP:   pattern = NLEDS'(1) << posNext;
      BLINK:   pattern = {NLEDS{blinkNext}};
      default: pattern = '0;
    endcase
  end

`ifdef LED_PWM_EN
  logic [2:0] pwm;

  always_ff @(posedge CLK) begin
    if (RESET) pwm <= '0;
    else       pwm <= pwm + 3'd1;
  end

  // Full brightness bypasses the duty comparison so the LEDs never flicker off.
  always_comb begin
    if (brightness == 3'd7 || pwm < brightness) ledsNext = pattern;
    else                                        ledsNext = '0;
  end
`else
  assign ledsNext = pattern;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div      <= '0;
      state    <= COUNT;
      count    <= '0;
      pos      <= '0;
      dirDown  <= 1'b0;
      blink    <= 1'b0;
      prevNext <= 1'b1;
      LEDS     <= '0;
    end else begin
      prevNext <= next_mode;
      if (modeEdge)    div <= '0;
      else if (!pause) div <= div + SLOW'(1);
      state   <= stateNext;
      count   <= countNext;
      pos     <= posNext;
      dirDown <= dirDownNext;
      blink   <= blinkNext;
      LEDS    <= ledsNext;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: a steps-since-mode-entry model checked every cycle, plus literal spot checks.
module tb_led_pattern_sequencer;

  localparam int SLOW   = 2;
  localparam int NLEDS  = 5;
  localparam int DIVMAX = (1 << SLOW) - 1;

  logic             CLK;
  logic             RESET;
  logic             next_mode;
  logic             pause;
  logic             tick;
  logic [1:0]       mode;
  logic [NLEDS-1:0] LEDS;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  int               mDiv;
  int               mMode;
  int               mSteps;
  bit               mPrev;
  logic [NLEDS-1:0] mLeds;

  led_pattern_sequencer #(.SLOW(SLOW), .NLEDS(NLEDS)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .next_mode (next_mode),
    .pause     (pause),
    .tick      (tick),
    .mode      (mode),
    .LEDS      (LEDS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // The expected LED picture depends only on the mode and how many steps it has taken.
  function automatic logic [NLEDS-1:0] patternOf(input int md, input int k);
    logic [NLEDS-1:0] r;
    int per;
    int p;
    per = 2 * (NLEDS - 1);
    r   = '0;
    case (md)
      0: r = NLEDS'(k % (1 << NLEDS));
      1: begin
        p = k % per;
        if (p > NLEDS - 1) p = per - p;
        r = NLEDS'(1) << p;
      end
      2: r = (k % 2 == 1) ? {NLEDS{1'b1}} : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge CLK) begin
    bit edgeSeen;
    bit stepSeen;
    if (RESET) begin
      mDiv   = 0;
      mMode  = 0;
      mSteps = 0;
      mPrev  = 1'b1;
      mLeds  = '0;
    end else begin
      edgeSeen = next_mode && !mPrev;
      stepSeen = (mDiv == DIVMAX) && !pause;
      mPrev    = next_mode;
      if (edgeSeen) begin
        mMode  = (mMode + 1) % 4;
        mSteps = 0;
        mDiv   = 0;
      end else begin
        if (stepSeen) mSteps++;
        if (!pause) mDiv = (mDiv + 1) % (1 << SLOW);
      end
      mLeds = patternOf(mMode, mSteps);
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      checks++;
      if (tick !== ((mDiv == DIVMAX) && !pause)) begin
        failures++;
        $display("[TB] FAIL cyc_tick t=%0t got %b expected %b", $time, tick, (mDiv == DIVMAX) && !pause);
      end
      checks++;
      if (mode !== 2'(mMode)) begin
        failures++;
        $display("[TB] FAIL cyc_mode t=%0t got %0d expected %0d", $time, mode, mMode);
      end
      checks++;
      if (LEDS !== mLeds) begin
        failures++;
        $display("[TB] FAIL cyc_leds t=%0t got %b expected %b", $time, LEDS, mLeds);
      end
    end
  end

  task automatic applyStimulus(input logic nm, input logic ps, input logic rs);
    @(posedge CLK);
    #1;
    next_mode = nm;
    pause     = ps;
    RESET     = rs;
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sweepExp[9] = '{2, 4, 8, 16, 8, 4, 2, 1, 2};
    int blinkExp[4] = '{31, 0, 31, 0};

    RESET     = 1'b1;
    next_mode = 1'b0;
    pause     = 1'b0;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    checkEn = 1;

    // Reset state and prescaler cadence in COUNT.
    waitNeg(1);
    checkOutput("reset_mode", mode, 0);
    checkOutput("reset_leds", LEDS, 0);
    checkOutput("reset_tick", tick, 0);
    waitNeg(2);
    checkOutput("tick_c3", tick, 0);
    waitNeg(1);
    checkOutput("tick_c4", tick, 1);
    waitNeg(1);
    checkOutput("count_1", LEDS, 1);
    waitNeg(3);
    checkOutput("tick_c8", tick, 1);
    waitNeg(1);
    checkOutput("count_2", LEDS, 2);
    waitNeg(4);
    checkOutput("count_3", LEDS, 3);
    waitNeg(112);
    checkOutput("count_31", LEDS, 31);
    waitNeg(4);
    checkOutput("count_wrap", LEDS, 0);

    // SWEEP bounce.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    waitNeg(1);
    checkOutput("sweep_mode", mode, 1);
    checkOutput("sweep_start", LEDS, 1);
    for (int k = 0; k < 9; k++) begin
      waitNeg(4);
      checkOutput($sformatf("sweep_step%0d", k + 1), LEDS, sweepExp[k]);
    end

    // BLINK.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    waitNeg(1);
    checkOutput("blink_mode", mode, 2);
    checkOutput("blink_start", LEDS, 0);
    for (int k = 0; k < 4; k++) begin
      waitNeg(4);
      checkOutput($sformatf("blink_step%0d", k + 1), LEDS, blinkExp[k]);
    end

    // OFF keeps ticking with dark LEDs.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    waitNeg(1);
    checkOutput("off_mode", mode, 3);
    waitNeg(3);
    checkOutput("off_tick", tick, 1);
    checkOutput("off_leds", LEDS, 0);
    waitNeg(4);
    checkOutput("off_tick2", tick, 1);

    // Wrap back to COUNT, then pause at count=5, div=2.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    waitNeg(1);
    checkOutput("wrap_mode", mode, 0);
    waitNeg(20);
    checkOutput("pause_pre", LEDS, 5);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      waitNeg(1);
      checkOutput($sformatf("pause_tick%0d", i), tick, 0);
      checkOutput($sformatf("pause_leds%0d", i), LEDS, 5);
      applyStimulus(0, (i < 9) ? 1'b1 : 1'b0, 0);
    end
    waitNeg(1);
    checkOutput("resume_notick", tick, 0);
    waitNeg(1);
    checkOutput("resume_tick", tick, 1);
    waitNeg(1);
    checkOutput("resume_leds", LEDS, 6);

    // Mode edge coinciding with a step: step discarded.
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    waitNeg(1);
    checkOutput("collide_tick", tick, 1);
    applyStimulus(0, 0, 0);
    waitNeg(1);
    checkOutput("collide_mode", mode, 1);
    checkOutput("collide_leds", LEDS, 1);

    // Mode edge while paused.
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    waitNeg(1);
    checkOutput("pedge_mode", mode, 2);
    checkOutput("pedge_leds", LEDS, 0);
    checkOutput("pedge_tick", tick, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    waitNeg(10);

    // next_mode held high across reset release.
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    waitNeg(1);
    checkOutput("rhold_mode", mode, 0);
    checkOutput("rhold_leds", LEDS, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    waitNeg(1);
    checkOutput("rhold_mode2", mode, 0);
    applyStimulus(0, 0, 0);
    waitNeg(6);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    waitNeg(1);
    checkOutput("post_reset_adv", mode, 1);
    waitNeg(8);

    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller that drives the board LED bank with selectable animated patterns instead of a bare free-running counter.
- Built-in power-of-two prescaler generates the pattern step tick, so no external slow clock is needed.
- A 4-state mode FSM selects the pattern. A `next_mode` button steps the mode; `pause` freezes animation.
- Sits between the clock/reset conditioning and the top-level LEDS output.

Parameters:
- SLOW, 21: prescaler width; one pattern step every 2^SLOW clock cycles. Must be ≥1; benches use 2.
- NLEDS, 5: number of LEDs driven. Must be ≥2.

Ports:
- CLK  input  1  system clock; all logic is on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- next_mode  input  1  mode-advance request, level; rising edge detected internally.
- pause  input  1  while high, prescaler and pattern state hold.
- tick  output  1  one-cycle pulse on each pattern step.
- mode  output  2  current mode: 0 COUNT, 1 SWEEP, 2 BLINK, 3 OFF.
- LEDS  output  NLEDS  LED drive, registered.

Behaviour:
- Reset (synchronous, RESET=1 at a rising edge):
  - div=0, mode=0, count=0, pos=0, dir=up, blink=0, tick=0, LEDS=0.
  - Edge-detect register loads 1, so next_mode held high through reset release causes no advance.
- Prescaler:
  - div is SLOW bits, increments each cycle when pause=0 and holds when pause=1.
  - Internal step = (div == 2^SLOW-1) && !pause.
  - tick is combinational and equals step. Period is exactly 2^SLOW cycles when unpaused.
- Pattern state updates at the end of a step cycle; the new LEDS value is visible the next cycle (1-cycle latency from tick).
- COUNT (mode 0):
  - count (NLEDS bits) increments on each step and wraps from 2^NLEDS-1 to 0.
  - LEDS=count.
- SWEEP (mode 1):
  - LEDS one-hot at bit pos.
  - On step with dir=up: pos+1. When pos reaches NLEDS-1, dir flips to down.
  - On step with dir=down: pos-1. When pos reaches 0, dir flips to up.
  - The end LEDs are lit for exactly one step each (sequence 0,1,..,N-1,N-2,..,0,1..).
- BLINK (mode 2): blink toggles on each step; LEDS = all-ones when blink=1, else 0.
- OFF (mode 3): LEDS=0. Prescaler still runs and tick still pulses.
- Mode advance:
  - Rising edge of next_mode (next_mode=1, prev=0) sets mode to mode+1 mod 4.
  - The same cycle it clears div, count, pos, blink and sets dir=up.
  - LEDS shows the new mode's initial pattern next cycle: COUNT 0, SWEEP bit0, BLINK 0, OFF 0.
- Simultaneous events:
  - Edge and step in the same cycle: mode change wins and the step is discarded (tick still pulses that cycle).
  - Edge while pause=1: mode advances; pattern and div are reset and then held while pause remains.
- pause asserted mid-period: div freezes at its current value; resume continues the count, with no restart and no lost step.
- RESET mid-operation has priority over all other inputs.

Optional Feature:
- Macro: LED_PWM_EN.
- When defined:
  - Adds input `brightness` [2:0] and a free-running 3-bit pwm counter (reset 0).
  - LEDS = pattern AND (pwm < brightness), except brightness=7, which forces full on.
  - brightness=0 means LEDS always 0.
  - The LEDS register captures the gated value.
- When undefined: no brightness port, no pwm counter; LEDS = pattern exactly as above.

Test Plan:
- Reset/prescaler, SLOW=2, NLEDS=5: hold RESET 3 cycles then release, next_mode=0, pause=0 -> LEDS=0, mode=0, and tick pulses on cycles 4, 8, 12 after release. LEDS reads 1, 2, 3 on the cycles after each tick, and wraps 31->0 after 32 ticks.
- Sweep bounce: pulse next_mode once -> mode=1, LEDS=00001. Subsequent step values are 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010.
- Mode wrap + blink/off: 3 more next_mode edges -> modes 2, 3, 0. In mode 2, LEDS alternates 11111/00000 per tick. In mode 3, LEDS stays 0 while tick keeps pulsing.
- Pause: assert pause with div=2 in COUNT at count=5 for 10 cycles -> no tick and LEDS=5 throughout. Release -> tick 2 cycles later, LEDS=6.
- Collision / reset hold: next_mode edge on a step cycle -> mode advances, count stays 0. next_mode held high across RESET release -> mode stays 0.
- LED_PWM_EN: BLINK, brightness=2 -> LEDS on for 2 of every 8 cycles while blink=1. brightness=7 -> continuously on. brightness=0 -> always 0.
